kernel_ram_read_ctrl: RTL and testbench
=======================================

Name: kernel_ram_read_ctrl

Overview:
Generalised kernel-RAM read address controller for the expand/convolution engines. Streams kernel-slice addresses out of a kernel RAM split into NUM_BANKS equal banks, each filled by an upstream loader. Each slice is replayed once per output row pass, then its bank is released back to the loader. Slices are consumed in bank round-robin order until the layer's depth is exhausted.

Parameters:
ADDR_W, 7, kernel RAM address width
NUM_BANKS, 2, number of kernel banks (≥1); bank b base address = b*BANK_SIZE
BANK_SIZE, 64, words per bank; NUM_BANKS*BANK_SIZE ≤ 2^ADDR_W (elaboration error otherwise)
LIMIT_W, 7, width of per-slice address limit
DEPTH_W, 6, width of slice count
DIM_W, 7, width of pass count
LOOKAHEAD, 4, warning distance for optional feature

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  latch config, (re)start layer; aborts any run in progress
ker_addr_limit_i  in  LIMIT_W  words per slice minus 1
ker_depth_i  in  DEPTH_W  slices per layer minus 1
layer_dimension_i  in  DIM_W  passes per slice minus 1
bank_ready_i  in  NUM_BANKS  level per bank: bank loaded
bank_done_o  out  NUM_BANKS  one-cycle pulse per bank: bank released
ker_req_i  in  1  consumer requests one kernel word
ker_ready_o  out  1  controller can serve ker_req_i
ram_rd_addr_o  out  ADDR_W  kernel RAM read address (word consumed on handshake)
ram_rd_valid_o  out  1  RAM data valid (handshake delayed 1 cycle)
fire_end_o  out  1  one-cycle pulse: layer complete
busy_o  out  1  high from start accepted until fire_end_o
bank_warn_o  out  1  see Optional Feature

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; all counters 0.
- Priority: rst_i > start_i > normal operation.
- Handshake: hs = ker_req_i & ker_ready_o. The word at ram_rd_addr_o is consumed on hs; ram_rd_valid_o = hs registered one cycle.
- ker_req_i without ker_ready_o is ignored.
- Counters: addr_off (LIMIT_W), pass_cnt (DIM_W), slice_cnt (DEPTH_W), bank_idx (max(1,clog2 NUM_BANKS)).
- ram_rd_addr_o = bank_idx*BANK_SIZE + addr_off, registered.
- On start_i, latch config and clamp: lim = min(ker_addr_limit_i, BANK_SIZE-1).
- States:
  - IDLE: outputs low. start_i → WAIT_BANK; counters cleared, busy_o=1.
  - WAIT_BANK: ker_ready_o=0. When bank_ready_i[bank_idx]=1 → READ; ker_ready_o rises the next cycle.
  - READ: ker_ready_o=1. bank_ready_i is not re-sampled; the loader holds it until done. On each hs:
    - addr_off<lim: addr_off+1.
    - addr_off==lim and pass_cnt<dim: addr_off=0, pass_cnt+1 (replay slice; no gap, ker_ready_o stays 1).
    - addr_off==lim and pass_cnt==dim: bank_done_o[bank_idx] pulses the next cycle, addr_off=0, pass_cnt=0.
      - If slice_cnt<depth: slice_cnt+1, bank_idx = (bank_idx+1) mod NUM_BANKS, → WAIT_BANK (ker_ready_o drops the next cycle).
      - Else: fire_end_o pulses in the same cycle as the final bank_done_o; → IDLE, busy_o=0.
- Wrap: slice k uses bank k mod NUM_BANKS. A reused bank must see bank_ready_i re-asserted; a level still high from the previous fill counts as ready, so the loader must drop it on bank_done_o.
- NUM_BANKS=1: every slice uses bank 0.
- Edge configs: lim=0 → one word per pass; dim=0 → single pass; depth=0 → single slice.
- start_i in any state (including mid-READ):
  - next cycle: ker_ready_o=0, ram_rd_addr_o=0, WAIT_BANK with fresh config.
  - no bank_done_o or fire_end_o pulses for the aborted run.
  - a hs in the same cycle as start_i is discarded; ram_rd_valid_o still follows it.
- rst_i mid-operation: IDLE, all outputs 0 next cycle.

Optional Feature:
Macro KER_RD_LOOKAHEAD_EN.
- Defined: bank_warn_o pulses one cycle after the hs where pass_cnt==dim and addr_off==lim-LOOKAHEAD. If lim<LOOKAHEAD, it pulses after the first hs of the final pass. It is not asserted on the final slice of the layer. Lets the loader prefetch the next bank.
- Not defined: bank_warn_o tied 0, lookahead logic absent.

Test Plan:
1. Defaults; lim=3, depth=1, dim=1; bank_ready_i=2'b11; ker_req_i=1 → hs addresses 0,1,2,3,0,1,2,3,64,65,66,67,64,65,66,67. Then bank_done_o=01 one cycle after 8th hs, 10 after 16th; fire_end_o coincident with the second pulse; ker_ready_o low during the WAIT_BANK cycle(s).
2. Same config, bank_ready_i[1] held 0 until 20 cycles after bank_done_o[0] → ker_ready_o 0 throughout; ram_rd_addr_o holds 64; reading resumes at 64 the cycle after ready+1.
3. Random ker_req_i gaps (50% duty) → identical address sequence to scenario 1; ram_rd_valid_o count = 16.
4. start_i asserted at third hs of scenario 1 → next cycle ker_ready_o=0, ram_rd_addr_o=0, no bank_done_o/fire_end_o; the restarted run completes normally.
5. ker_addr_limit_i=100, depth=2, dim=0 → each slice reads 0..63 / 64..127 / 0..63. Third slice waits until bank_ready_i[0] is re-asserted after its bank_done_o pulse.
6. KER_RD_LOOKAHEAD_EN defined, lim=7, dim=0, depth=1 → bank_warn_o one cycle after hs at address 3, none on slice 2. Undefined: bank_warn_o constant 0.

Source files
------------

// File: rtl/kernel_ram_read_ctrl.sv
// Kernel-RAM read address controller: streams slice addresses from NUM_BANKS banks,
// replaying each slice per pass. Define KER_RD_LOOKAHEAD_EN for the bank prefetch warning.
module kernel_ram_read_ctrl #(
    parameter int ADDR_W    = 7,
    parameter int NUM_BANKS = 2,
    parameter int BANK_SIZE = 64,
    parameter int LIMIT_W   = 7,
    parameter int DEPTH_W   = 6,
    parameter int DIM_W     = 7,
    parameter int LOOKAHEAD = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [LIMIT_W-1:0]   ker_addr_limit_i,
    input  logic [DEPTH_W-1:0]   ker_depth_i,
    input  logic [DIM_W-1:0]     layer_dimension_i,
    input  logic [NUM_BANKS-1:0] bank_ready_i,
    output logic [NUM_BANKS-1:0] bank_done_o,
    input  logic                 ker_req_i,
    output logic                 ker_ready_o,
    output logic [ADDR_W-1:0]    ram_rd_addr_o,
    output logic                 ram_rd_valid_o,
    output logic                 fire_end_o,
    output logic                 busy_o,
    output logic                 bank_warn_o
);

    localparam int BIDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    if ((NUM_BANKS < 1) || (NUM_BANKS * BANK_SIZE > (1 << ADDR_W))) begin : g_bad_cfg
        $error("kernel_ram_read_ctrl: bank layout does not fit the address space");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BANK = 2'd1,
        ST_READ      = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [LIMIT_W-1:0]   addr_off_r, addr_off_s;
    logic [DIM_W-1:0]     pass_cnt_r, pass_cnt_s;
    logic [DEPTH_W-1:0]   slice_cnt_r, slice_cnt_s;
    logic [BIDX_W-1:0]    bank_idx_r, bank_idx_s, bank_next_s;
    logic [LIMIT_W-1:0]   lim_r, lim_s, lim_in_s;
    logic [DEPTH_W-1:0]   depth_r, depth_s;
    logic [DIM_W-1:0]     dim_r, dim_s;
    logic [NUM_BANKS-1:0] bank_done_r, bank_done_s;
    logic                 fire_end_r, fire_end_s;
    logic                 ker_ready_r, ram_rd_valid_r, busy_r;
    logic [ADDR_W-1:0]    ram_rd_addr_r, addr_s;
    logic                 hs_s;

    assign hs_s        = ker_req_i & ker_ready_r;
    assign bank_next_s = (bank_idx_r == BIDX_W'(NUM_BANKS - 1)) ? '0 : bank_idx_r + BIDX_W'(1);
    // A slice can never be longer than its bank
    assign lim_in_s    = (32'(ker_addr_limit_i) > 32'(BANK_SIZE - 1)) ? LIMIT_W'(BANK_SIZE - 1)
                                                                      : ker_addr_limit_i;
    assign addr_s      = ADDR_W'(bank_idx_s) * ADDR_W'(BANK_SIZE) + ADDR_W'(addr_off_s);

    // Next-state and counter update; start_i overrides everything, including a same-cycle handshake
    always_comb begin
        state_s     = state_r;
        addr_off_s  = addr_off_r;
        pass_cnt_s  = pass_cnt_r;
        slice_cnt_s = slice_cnt_r;
        bank_idx_s  = bank_idx_r;
        lim_s       = lim_r;
        depth_s     = depth_r;
        dim_s       = dim_r;
        bank_done_s = '0;
        fire_end_s  = 1'b0;
        if (start_i) begin
            state_s     = ST_WAIT_BANK;
            addr_off_s  = '0;
            pass_cnt_s  = '0;
            slice_cnt_s = '0;
            bank_idx_s  = '0;
            lim_s       = lim_in_s;
            depth_s     = ker_depth_i;
            dim_s       = layer_dimension_i;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_WAIT_BANK: begin
                    if (bank_ready_i[bank_idx_r]) begin
                        state_s = ST_READ;
                    end else begin
                        state_s = ST_WAIT_BANK;
                    end
                end
                ST_READ: begin
                    if (!hs_s) begin
                        state_s = ST_READ;
                    end else if (addr_off_r < lim_r) begin
                        addr_off_s = addr_off_r + LIMIT_W'(1);
                    end else if (pass_cnt_r < dim_r) begin
                        addr_off_s = '0;
                        pass_cnt_s = pass_cnt_r + DIM_W'(1);
                    end else begin
                        addr_off_s              = '0;
                        pass_cnt_s              = '0;
                        bank_done_s[bank_idx_r] = 1'b1;
                        if (slice_cnt_r < depth_r) begin
                            slice_cnt_s = slice_cnt_r + DEPTH_W'(1);
                            bank_idx_s  = bank_next_s;
                            state_s     = ST_WAIT_BANK;
                        end else begin
                            fire_end_s = 1'b1;
                            state_s    = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r        <= ST_IDLE;
            addr_off_r     <= '0;
            pass_cnt_r     <= '0;
            slice_cnt_r    <= '0;
            bank_idx_r     <= '0;
            lim_r          <= '0;
            depth_r        <= '0;
            dim_r          <= '0;
            bank_done_r    <= '0;
            fire_end_r     <= 1'b0;
            ker_ready_r    <= 1'b0;
            ram_rd_addr_r  <= '0;
            ram_rd_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            addr_off_r     <= addr_off_s;
            pass_cnt_r     <= pass_cnt_s;
            slice_cnt_r    <= slice_cnt_s;
            bank_idx_r     <= bank_idx_s;
            lim_r          <= lim_s;
            depth_r        <= depth_s;
            dim_r          <= dim_s;
            bank_done_r    <= bank_done_s;
            fire_end_r     <= fire_end_s;
            ker_ready_r    <= (state_s == ST_READ);
            ram_rd_addr_r  <= addr_s;
            ram_rd_valid_r <= hs_s;
            busy_r         <= (state_s != ST_IDLE);
        end
    end

    assign bank_done_o    = bank_done_r;
    assign fire_end_o     = fire_end_r;
    assign ker_ready_o    = ker_ready_r;
    assign ram_rd_addr_o  = ram_rd_addr_r;
    assign ram_rd_valid_o = ram_rd_valid_r;
    assign busy_o         = busy_r;

`ifdef KER_RD_LOOKAHEAD_EN
    logic [LIMIT_W-1:0] warn_off_s;
    logic               bank_warn_s, bank_warn_r;

    // Offset within the final pass at which the loader is told to prefetch the next bank
    always_comb begin
        if (lim_r >= LIMIT_W'(LOOKAHEAD)) begin
            warn_off_s = lim_r - LIMIT_W'(LOOKAHEAD);
        end else begin
            warn_off_s = '0;
        end
        if ((state_r == ST_READ) && hs_s && !start_i && (pass_cnt_r == dim_r) &&
            (slice_cnt_r < depth_r) && (addr_off_r == warn_off_s)) begin
            bank_warn_s = 1'b1;
        end else begin
            bank_warn_s = 1'b0;
        end
    end

    // Registered warning pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bank_warn_r <= 1'b0;
        end else begin
            bank_warn_r <= bank_warn_s;
        end
    end

    assign bank_warn_o = bank_warn_r;
`else
    assign bank_warn_o = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_ram_read_ctrl.sv
// Directed self-checking bench for kernel_ram_read_ctrl (2 banks of 64 words).
module tb_kernel_ram_read_ctrl;

`ifdef KER_RD_LOOKAHEAD_EN
    localparam bit WARN_EN = 1'b1;
`else
    localparam bit WARN_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i, start_i, ker_req_i;
    logic [6:0] ker_addr_limit_i;
    logic [5:0] ker_depth_i;
    logic [6:0] layer_dimension_i;
    logic [1:0] bank_ready_i, bank_done_o;
    logic       ker_ready_o, ram_rd_valid_o, fire_end_o, busy_o, bank_warn_o;
    logic [6:0] ram_rd_addr_o;

    kernel_ram_read_ctrl dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .ker_addr_limit_i  (ker_addr_limit_i),
        .ker_depth_i       (ker_depth_i),
        .layer_dimension_i (layer_dimension_i),
        .bank_ready_i      (bank_ready_i),
        .bank_done_o       (bank_done_o),
        .ker_req_i         (ker_req_i),
        .ker_ready_o       (ker_ready_o),
        .ram_rd_addr_o     (ram_rd_addr_o),
        .ram_rd_valid_o    (ram_rd_valid_o),
        .fire_end_o        (fire_end_o),
        .busy_o            (busy_o),
        .bank_warn_o       (bank_warn_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // reference model: state 0 idle, 1 wait bank, 2 read
    int   m_state, m_off, m_pass, m_slice, m_bank, m_lim, m_dim, m_depth, m_addr;
    bit   m_rdy, m_valid, m_fire, m_busy, m_warn;
    logic [1:0] m_done;
    int   rdy_cnt [2];
    int   hs_log [$];
    int   valid_seen, done_seen, fire_seen, warn_seen;
    int   exp1 [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 64, 65, 66, 67, 64, 65, 66, 67};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, ker_ready_o, 0);
        chk({tag, "_addr"}, ram_rd_addr_o, 0);
        chk({tag, "_valid"}, ram_rd_valid_o, 0);
        chk({tag, "_done"}, bank_done_o, 0);
        chk({tag, "_fire"}, fire_end_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_warn"}, bank_warn_o, 0);
    endtask

    task automatic model_edge(input bit start, input bit req);
        bit hs;
        int woff;
        hs      = req && m_rdy;
        m_valid = hs;
        m_done  = 2'b00;
        m_fire  = 1'b0;
        m_warn  = 1'b0;
        if (start) begin
            m_state = 1; m_off = 0; m_pass = 0; m_slice = 0; m_bank = 0;
            m_lim   = (ker_addr_limit_i > 7'd63) ? 63 : int'(ker_addr_limit_i);
            m_dim   = int'(layer_dimension_i);
            m_depth = int'(ker_depth_i);
        end else if (m_state == 1) begin
            if (bank_ready_i[m_bank] == 1'b1) m_state = 2;
        end else if (m_state == 2 && hs) begin
            hs_log.push_back(m_addr);
            woff = (m_lim >= 4) ? m_lim - 4 : 0;
            if (WARN_EN && m_pass == m_dim && m_slice < m_depth && m_off == woff) m_warn = 1'b1;
            if (m_off < m_lim) begin
                m_off++;
            end else if (m_pass < m_dim) begin
                m_off = 0; m_pass++;
            end else begin
                m_off = 0; m_pass = 0;
                m_done[m_bank] = 1'b1;
                if (m_slice < m_depth) begin
                    m_slice++; m_bank = (m_bank + 1) % 2; m_state = 1;
                end else begin
                    m_fire = 1'b1; m_state = 0;
                end
            end
        end
        m_rdy  = (m_state == 2);
        m_busy = (m_state != 0);
        m_addr = m_bank * 64 + m_off;
    endtask

    task automatic check_outputs();
        chk("ker_ready", ker_ready_o, m_rdy);
        if (m_state != 0) chk("rd_addr", ram_rd_addr_o, m_addr);
        chk("rd_valid", ram_rd_valid_o, m_valid);
        chk("bank_done", bank_done_o, m_done);
        chk("fire_end", fire_end_o, m_fire);
        chk("busy", busy_o, m_busy);
        chk("bank_warn", bank_warn_o, m_warn);
        valid_seen += int'(ram_rd_valid_o);
        done_seen  += int'(bank_done_o != 2'b00);
        fire_seen  += int'(fire_end_o);
        warn_seen  += int'(bank_warn_o);
    endtask

    // one layer run; loader drops bank b for 'reload' cycles after its bank_done,
    // 'gate1' releases bank 1 that many cycles after bank 0 is done
    task automatic run(input int lim, input int dep, input int dim, input bit rnd,
                       input int init1, input int gate1, input int reload, input int abort_hs);
        int cyc;
        ker_addr_limit_i  = 7'(lim);
        ker_depth_i       = 6'(dep);
        layer_dimension_i = 7'(dim);
        rdy_cnt[0] = 0;
        rdy_cnt[1] = init1;
        bank_ready_i = {rdy_cnt[1] == 0, rdy_cnt[0] == 0};
        hs_log.delete();
        valid_seen = 0; done_seen = 0; fire_seen = 0; warn_seen = 0;
        ker_req_i = 1'b0;
        start_i   = 1'b1;
        model_edge(1'b1, 1'b0);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cyc = 0;
        while (cyc < 2000) begin
            check_outputs();
            if (m_state == 0) break;
            for (int b = 0; b < 2; b++) begin
                if (rdy_cnt[b] > 0) rdy_cnt[b]--;
                if (m_done[b] && reload > 0) rdy_cnt[b] = reload;
            end
            if (m_done[0] && gate1 > 0) begin
                rdy_cnt[1] = gate1;
                gate1 = 0;
            end
            bank_ready_i = {rdy_cnt[1] == 0, rdy_cnt[0] == 0};
            ker_req_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (abort_hs >= 0 && hs_log.size() == abort_hs && ker_req_i && m_rdy) begin
                start_i  = 1'b1;
                abort_hs = -1;
                model_edge(1'b1, ker_req_i);
                hs_log.delete();
            end else begin
                model_edge(1'b0, ker_req_i);
            end
            @(posedge clk_i); #1;
            start_i = 1'b0;
            cyc++;
        end
        ker_req_i = 1'b0;
        if (cyc >= 2000) begin
            n_vec++;
            n_err++;
            $error("FAIL run_timeout observed=%0d cycles expected=layer end", cyc);
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; ker_req_i = 1'b0; bank_ready_i = 2'b00;
        ker_addr_limit_i = 7'd0; ker_depth_i = 6'd0; layer_dimension_i = 7'd0;
        repeat (2) @(posedge clk_i);
        #1;
        chk_zero("reset");
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk_zero("idle");

        // 1: two slices, two passes of four words
        run(3, 1, 1, 1'b0, 0, 0, 0, -1);
        chk("s1_hs_count", hs_log.size(), 16);
        for (int i = 0; i < 16 && i < hs_log.size(); i++) chk($sformatf("s1_addr%0d", i), hs_log[i], exp1[i]);
        chk("s1_done_pulses", done_seen, 2);
        chk("s1_fire_pulses", fire_seen, 1);

        // 2: bank 1 released 20 cycles after bank 0 is done
        run(3, 1, 1, 1'b0, 100000, 20, 0, -1);
        chk("s2_hs_count", hs_log.size(), 16);
        for (int i = 0; i < 16 && i < hs_log.size(); i++) chk($sformatf("s2_addr%0d", i), hs_log[i], exp1[i]);

        // 3: random request gaps
        run(3, 1, 1, 1'b1, 0, 0, 0, -1);
        chk("s3_hs_count", hs_log.size(), 16);
        for (int i = 0; i < 16 && i < hs_log.size(); i++) chk($sformatf("s3_addr%0d", i), hs_log[i], exp1[i]);
        chk("s3_valid_count", valid_seen, 16);

        // 4: restart on the third handshake
        run(3, 1, 1, 1'b0, 0, 0, 0, 2);
        chk("s4_hs_count", hs_log.size(), 16);
        for (int i = 0; i < 16 && i < hs_log.size(); i++) chk($sformatf("s4_addr%0d", i), hs_log[i], exp1[i]);
        chk("s4_done_pulses", done_seen, 2);
        chk("s4_fire_pulses", fire_seen, 1);

        // 5: clamped limit, three slices wrapping onto bank 0 after a refill
        run(100, 2, 0, 1'b0, 0, 0, 80, -1);
        chk("s5_hs_count", hs_log.size(), 192);
        for (int i = 0; i < 192 && i < hs_log.size(); i++)
            chk($sformatf("s5_addr%0d", i), hs_log[i], (i < 128) ? i : i - 128);
        chk("s5_done_pulses", done_seen, 3);

        // 6: lookahead warning
        run(7, 1, 0, 1'b0, 0, 0, 0, -1);
        chk("s6_warn_pulses", warn_seen, WARN_EN ? 1 : 0);
        chk("s6_hs_count", hs_log.size(), 16);

        // 7: single word, single pass, single slice
        run(0, 0, 0, 1'b0, 0, 0, 0, -1);
        chk("s7_hs_count", hs_log.size(), 1);
        chk("s7_fire_pulses", fire_seen, 1);

        // 8: reset in the middle of a read
        ker_addr_limit_i = 7'd3; ker_depth_i = 6'd1; layer_dimension_i = 7'd1;
        bank_ready_i = 2'b11; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; ker_req_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        chk("s8_busy_before_reset", busy_o, 1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk_zero("s8_reset");
        rst_i = 1'b0; ker_req_i = 1'b0;
        @(posedge clk_i); #1;
        chk_zero("s8_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
